// File: rtl/asm_seq_if.sv
// Handshake and memory-control bundle for asm_seq_ctrl.
//   master : pass requester / memory side (drives start, stall)
//   slave  : the sequencer (drives strobes, addresses and status)
interface asm_seq_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              start;
   logic              stall;
   logic              rd_en;
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] wgt_addr;
   logic              bn_rd_en;
   logic [ADDR_W-1:0] bn_addr;
   logic              calculate_en;
   logic              asm_send;
   logic              asm_reception;
   logic              pix_null;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              busy;
   logic              done;

   modport master (
      output start, stall,
      input  rd_en, pix_addr, wgt_addr, bn_rd_en, bn_addr, calculate_en,
             asm_send, asm_reception, pix_null, wr_en, wr_addr, busy, done
   );

   modport slave (
      input  start, stall,
      output rd_en, pix_addr, wgt_addr, bn_rd_en, bn_addr, calculate_en,
             asm_send, asm_reception, pix_null, wr_en, wr_addr, busy, done
   );
endinterface

// File: rtl/asm_seq_ctrl.sv
// asm_seq_ctrl: sequences one binary-conv layer pass. Issues KERNEL_LEN pixel/
// weight reads per output for NUM_OUT outputs, then swaps accumulator banks,
// loads BN coefficients and writes the thresholded bit to next-layer SRAM.
// Ports: clk, rst (sync, active-high); bus (asm_seq_if.slave):
//   start/stall in; rd_en, pix_addr, wgt_addr, bn_rd_en, bn_addr,
//   calculate_en, asm_send, asm_reception, pix_null, wr_en, wr_addr,
//   busy, done out. All outputs are registered.
// Build option: define ASM_SEQ_STALL_EN to honour stall; otherwise stall is
// ignored and pix_null only marks DRAIN bubbles.
module asm_seq_ctrl #(
   parameter int unsigned KERNEL_LEN = 9,
   parameter int unsigned NUM_OUT    = 16,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned PIX_BASE   = 0,
   parameter int unsigned PIX_STRIDE = 1
) (
   input  logic     clk,
   input  logic     rst,
   asm_seq_if.slave bus
);
   localparam int unsigned K_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
   localparam int unsigned N_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(KERNEL_LEN - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_d;
   logic [K_W-1:0]    k, k_d;
   logic [N_W-1:0]    n, n_d;
   logic              v1, last1;
   logic [ADDR_W-1:0] snd_n, snd_n_d;
   logic              issue, final_wr, stall_eff;

   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
   logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
   logic              bn_rd_en_q, bn_rd_en_d;
   logic [ADDR_W-1:0] bn_addr_q, bn_addr_d;
   logic              calc_q, calc_d;
   logic              asm_q, asm_d;
   logic              pix_null_q, pix_null_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

`ifdef ASM_SEQ_STALL_EN
   assign stall_eff = bus.stall;
`else
   logic unused_stall;
   assign unused_stall = bus.stall;
   assign stall_eff    = 1'b0;
`endif

   // Next-state, counter and output-register decode
   always_comb begin
      state_d    = state;
      k_d        = k;
      n_d        = n;
      snd_n_d    = snd_n;
      pix_addr_d = pix_addr_q;
      wgt_addr_d = wgt_addr_q;
      bn_addr_d  = bn_addr_q;
      wr_addr_d  = wr_addr_q;
      bn_rd_en_d = 1'b0;

      issue    = (state == RUN) && !stall_eff;
      // Last write of the pass: nothing left in the read or send pipeline
      final_wr = (state == DRAIN) && wr_en_q && !rd_en_q && !(v1 && last1);

      case (state)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (issue && (k == K_LAST) && (n == N_LAST)) state_d = DRAIN;
         DRAIN:   if (final_wr) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue) begin
         pix_addr_d = ADDR_W'(PIX_BASE) + ADDR_W'(n) * ADDR_W'(PIX_STRIDE) + ADDR_W'(k);
         wgt_addr_d = ADDR_W'(k);
         if (k == K_LAST) begin
            k_d        = '0;
            n_d        = (n == N_LAST) ? '0 : n + N_W'(1);
            bn_rd_en_d = 1'b1;
            bn_addr_d  = ADDR_W'(n);
         end else begin
            k_d = k + K_W'(1);
         end
      end
      rd_en_d = issue;

      // Bank swap follows the last-tap read by one cycle (read latency)
      asm_d = rd_en_q && bn_rd_en_q;
      if (asm_d) snd_n_d = bn_addr_q;

      wr_en_d = asm_q;
      if (asm_q) wr_addr_d = snd_n;

      calc_d = (state == RUN) || ((state == DRAIN) && !final_wr);

`ifdef ASM_SEQ_STALL_EN
      pix_null_d = calc_q && !rd_en_q;
`else
      pix_null_d = (state_d == DRAIN) && !rd_en_q;
`endif

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, counters, pipeline and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         n          <= '0;
         v1         <= 1'b0;
         last1      <= 1'b0;
         snd_n      <= '0;
         rd_en_q    <= 1'b0;
         pix_addr_q <= '0;
         wgt_addr_q <= '0;
         bn_rd_en_q <= 1'b0;
         bn_addr_q  <= '0;
         calc_q     <= 1'b0;
         asm_q      <= 1'b0;
         pix_null_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_d;
         k          <= k_d;
         n          <= n_d;
         v1         <= rd_en_q;
         last1      <= bn_rd_en_q;
         snd_n      <= snd_n_d;
         rd_en_q    <= rd_en_d;
         pix_addr_q <= pix_addr_d;
         wgt_addr_q <= wgt_addr_d;
         bn_rd_en_q <= bn_rd_en_d;
         bn_addr_q  <= bn_addr_d;
         calc_q     <= calc_d;
         asm_q      <= asm_d;
         pix_null_q <= pix_null_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.rd_en         = rd_en_q;
   assign bus.pix_addr      = pix_addr_q;
   assign bus.wgt_addr      = wgt_addr_q;
   assign bus.bn_rd_en      = bn_rd_en_q;
   assign bus.bn_addr       = bn_addr_q;
   assign bus.calculate_en  = calc_q;
   assign bus.asm_send      = asm_q;
   assign bus.asm_reception = asm_q;
   assign bus.pix_null      = pix_null_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
endmodule

// File: tb/tb_asm_seq_ctrl.sv
// Bench for asm_seq_ctrl. Cycle c is the period after the c-th rising edge,
// counting from the edge that samples start.
module tb_asm_seq_ctrl;
   localparam int AW   = 10;
   localparam int KL   = 4;
   localparam int NO   = 3;
   localparam int PS   = 4;
   localparam int NCYC = 20;

   typedef struct {
      logic          start;
      logic          stall;
      logic          rd_en;
      logic [AW-1:0] pix_addr;
      logic [AW-1:0] wgt_addr;
      logic          bn_rd_en;
      logic [AW-1:0] bn_addr;
      logic          calc;
      logic          asm_send;
      logic          pix_null;
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic          busy;
      logic          done;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl [NCYC];
   vec_t sb [$];

   always #5 clk = ~clk;

   asm_seq_if #(.ADDR_W(AW)) bus_a ();
   asm_seq_if #(.ADDR_W(AW)) bus_b ();

   asm_seq_ctrl #(.KERNEL_LEN(KL), .NUM_OUT(NO), .ADDR_W(AW), .PIX_BASE(0), .PIX_STRIDE(PS))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   asm_seq_ctrl #(.KERNEL_LEN(1), .NUM_OUT(2), .ADDR_W(AW), .PIX_BASE(0), .PIX_STRIDE(1))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk1(input string nm, input int c, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: actual %b required %b", nm, c, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input int c, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: actual %0d required %0d", nm, c, act, exp);
      end
   endtask

   // Expected trace from the pass timing: issue i lands on the i-th
   // non-stalled edge; send one cycle later, write two cycles later.
   task automatic build_table(input logic [NCYC-1:0] stl);
      int i, k, n, last_wr, last_issue;
      bit honour;
`ifdef ASM_SEQ_STALL_EN
      honour = 1'b1;
`else
      honour = 1'b0;
`endif
      i = 0; last_wr = 0; last_issue = 0;
      for (int c = 0; c < NCYC; c++) begin
         tbl[c] = '{default: '0};
         tbl[c].stall = stl[c];
      end
      tbl[0].start = 1'b1;
      tbl[8].start = 1'b1;
      for (int c = 1; c < NCYC; c++) begin
         if (i < KL * NO && !(honour && stl[c])) begin
            k = i % KL;
            n = i / KL;
            tbl[c].rd_en    = 1'b1;
            tbl[c].pix_addr = AW'(n * PS + k);
            tbl[c].wgt_addr = AW'(k);
            if (k == KL - 1) begin
               tbl[c].bn_rd_en = 1'b1;
               tbl[c].bn_addr  = AW'(n);
               if (c + 1 < NCYC) tbl[c+1].asm_send = 1'b1;
               if (c + 2 < NCYC) begin
                  tbl[c+2].wr_en   = 1'b1;
                  tbl[c+2].wr_addr = AW'(n);
               end
               last_wr = c + 2;
            end
            last_issue = c;
            i++;
         end
      end
      for (int c = 0; c < NCYC; c++) begin
         tbl[c].calc = (c >= 1) && (c <= last_wr);
         tbl[c].busy = (c <= last_wr + 1);
         tbl[c].done = (c == last_wr + 1);
      end
      for (int c = 1; c < NCYC; c++) begin
         if (honour) tbl[c].pix_null = tbl[c-1].calc && !tbl[c-1].rd_en;
         else        tbl[c].pix_null = (c >= last_issue) && (c <= last_wr) && !tbl[c-1].rd_en;
      end
   endtask

   task automatic compare_row(input string tag, input int c, input vec_t r);
      chk1({tag, ".rd_en"}, c, bus_a.rd_en, r.rd_en);
      if (r.rd_en) begin
         chkw({tag, ".pix_addr"}, c, bus_a.pix_addr, r.pix_addr);
         chkw({tag, ".wgt_addr"}, c, bus_a.wgt_addr, r.wgt_addr);
      end
      chk1({tag, ".bn_rd_en"}, c, bus_a.bn_rd_en, r.bn_rd_en);
      if (r.bn_rd_en) chkw({tag, ".bn_addr"}, c, bus_a.bn_addr, r.bn_addr);
      chk1({tag, ".calculate_en"}, c, bus_a.calculate_en, r.calc);
      chk1({tag, ".asm_send"}, c, bus_a.asm_send, r.asm_send);
      chk1({tag, ".asm_reception"}, c, bus_a.asm_reception, r.asm_send);
      chk1({tag, ".pix_null"}, c, bus_a.pix_null, r.pix_null);
      chk1({tag, ".wr_en"}, c, bus_a.wr_en, r.wr_en);
      if (r.wr_en) chkw({tag, ".wr_addr"}, c, bus_a.wr_addr, r.wr_addr);
      chk1({tag, ".busy"}, c, bus_a.busy, r.busy);
      chk1({tag, ".done"}, c, bus_a.done, r.done);
   endtask

   task automatic run_table(input string tag);
      vec_t got;
      for (int c = 0; c < NCYC; c++) begin
         bus_a.start = tbl[c].start;
         bus_a.stall = tbl[c].stall;
         sb.push_back(tbl[c]);
         tick();
         got = sb.pop_front();
         compare_row(tag, c, got);
      end
      bus_a.start = 1'b0;
      bus_a.stall = 1'b0;
   endtask

   task automatic check_idle(input string tag, input int c);
      chk1({tag, ".rd_en"}, c, bus_a.rd_en, 1'b0);
      chkw({tag, ".pix_addr"}, c, bus_a.pix_addr, '0);
      chkw({tag, ".wgt_addr"}, c, bus_a.wgt_addr, '0);
      chk1({tag, ".bn_rd_en"}, c, bus_a.bn_rd_en, 1'b0);
      chkw({tag, ".bn_addr"}, c, bus_a.bn_addr, '0);
      chk1({tag, ".calculate_en"}, c, bus_a.calculate_en, 1'b0);
      chk1({tag, ".asm_send"}, c, bus_a.asm_send, 1'b0);
      chk1({tag, ".asm_reception"}, c, bus_a.asm_reception, 1'b0);
      chk1({tag, ".pix_null"}, c, bus_a.pix_null, 1'b0);
      chk1({tag, ".wr_en"}, c, bus_a.wr_en, 1'b0);
      chkw({tag, ".wr_addr"}, c, bus_a.wr_addr, '0);
      chk1({tag, ".busy"}, c, bus_a.busy, 1'b0);
      chk1({tag, ".done"}, c, bus_a.done, 1'b0);
   endtask

   // KERNEL_LEN=1, NUM_OUT=2 expected waveforms, bit c = cycle c
   logic [7:0] m_rd   = 8'b0000_0110;
   logic [7:0] m_asm  = 8'b0000_1100;
   logic [7:0] m_wr   = 8'b0001_1000;
   logic [7:0] m_calc = 8'b0001_1110;
   logic [7:0] m_busy = 8'b0011_1111;
   logic [7:0] m_done = 8'b0010_0000;
`ifdef ASM_SEQ_STALL_EN
   logic [7:0] m_null = 8'b0011_0000;
`else
   logic [7:0] m_null = 8'b0001_0000;
`endif

   initial begin
      logic [NCYC-1:0] stl;
      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.stall = 1'b0;
      bus_b.start = 1'b0; bus_b.stall = 1'b0;
      repeat (3) tick();
      check_idle("reset", 0);
      chk1("reset.b_busy", 0, bus_b.busy, 1'b0);
      rst = 1'b0;
      tick();

      // Nominal pass with a second start while busy
`ifdef ASM_SEQ_STALL_EN
      stl = '0;
`else
      stl = '1;
`endif
      build_table(stl);
      run_table("pass");

`ifdef ASM_SEQ_STALL_EN
      // Stall sampled at cycles 3 and 4
      stl = '0;
      stl[3] = 1'b1;
      stl[4] = 1'b1;
      build_table(stl);
      run_table("stall");
`endif

      // Reset at cycle 7 abandons the pass
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      chk1("midrst.calc_before", 6, bus_a.calculate_en, 1'b1);
      chk1("midrst.busy_before", 6, bus_a.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 8; c <= 22; c++) begin
         tick();
         check_idle("midrst", c);
      end
      if (stl[3] === 1'b1) stl = '0;
      build_table(stl);
      run_table("restart");

      // Single-tap kernel, two outputs
      for (int c = 0; c < 8; c++) begin
         bus_b.start = (c == 0);
         tick();
         chk1("k1.rd_en", c, bus_b.rd_en, m_rd[c]);
         chk1("k1.bn_rd_en", c, bus_b.bn_rd_en, m_rd[c]);
         if (m_rd[c]) begin
            chkw("k1.bn_addr", c, bus_b.bn_addr, AW'(c - 1));
            chkw("k1.pix_addr", c, bus_b.pix_addr, AW'(c - 1));
         end
         chk1("k1.asm_send", c, bus_b.asm_send, m_asm[c]);
         chk1("k1.asm_reception", c, bus_b.asm_reception, m_asm[c]);
         chk1("k1.wr_en", c, bus_b.wr_en, m_wr[c]);
         if (m_wr[c]) chkw("k1.wr_addr", c, bus_b.wr_addr, AW'(c - 3));
         chk1("k1.calculate_en", c, bus_b.calculate_en, m_calc[c]);
         chk1("k1.pix_null", c, bus_b.pix_null, m_null[c]);
         chk1("k1.busy", c, bus_b.busy, m_busy[c]);
         chk1("k1.done", c, bus_b.done, m_done[c]);
      end
      bus_b.start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
